// File: rtl/irq_pkg.sv
// Shared constants and state type for the interrupt request front-end.
package irq_pkg;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

endpackage

// File: rtl/prio_sel4.sv
// Combinational highest-set-bit selector; bit 3 wins, matching the downstream encoder.
module prio_sel4
  import irq_pkg::*;
(
  input  logic [NREQ-1:0] vec_i,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    any_o = |vec_i;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (vec_i[i]) idx_o = IDW'(i);
    end
  end

endmodule

// File: rtl/irq_pend4.sv
// Four-line IRQ front-end: synchronise, capture into sticky pending bits,
// mask, and issue one request at a time with an IRQ/ACK handshake.
module irq_pend4
  import irq_pkg::*;
#(
  parameter int unsigned EDGE = 1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [NREQ-1:0] REQ,
  input  logic [NREQ-1:0] MASK,
  input  logic            ACK,
  output logic [NREQ-1:0] PEND,
  output logic            IRQ,
  output logic [IDW-1:0]  ID,
  output logic [NREQ-1:0] OVF
);

  logic [NREQ-1:0] s1_q, s2_q, s3_q;
  logic [1:0]      fill_q;
  logic [NREQ-1:0] pend_q, pend_d;
  logic [NREQ-1:0] ovf_q, ovf_d;
  logic            irq_q, irq_d;
  logic [IDW-1:0]  id_q, id_d;
  state_e          state_q, state_d;

  logic [NREQ-1:0] ev;
  logic [NREQ-1:0] clr;
  logic [IDW-1:0]  sel_idx;
  logic            sel_any;

  // Three-stage synchroniser plus a fill counter; fill_q saturates at 3 once
  // s3 holds a genuine post-reset sample.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      fill_q <= '0;
    end else begin
      s1_q   <= REQ;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      fill_q <= (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
    end
  end

  // Capture events are held off until the chain has refilled after reset, so a
  // line already high at release reads as a level, not as a fresh rising edge.
  always_comb begin
    ev = '0;
    if (fill_q == 2'd3) begin
      ev = (EDGE != 0) ? (s2_q & ~s3_q) : s2_q;
    end
  end

  // One-hot clear of the issued bit on acknowledge.
  always_comb begin
    clr = '0;
    if (state_q == ST_ISSUE && ACK) clr[id_q] = 1'b1;
  end

  // Pending and overflow next state; a same-cycle set wins over the clear.
  always_comb begin
    pend_d = (pend_q & ~clr) | ev;
    ovf_d  = '0;
    if (EDGE != 0) ovf_d = (ovf_q & ~clr) | (ev & pend_q & ~clr);
  end

  prio_sel4 u_sel (
    .vec_i (pend_q & MASK),
    .idx_o (sel_idx),
    .any_o (sel_any)
  );

  // Issue FSM next state: latch the winner in IDLE, hold it until ACK.
  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_any) begin
          state_d = ST_ISSUE;
          irq_d   = 1'b1;
          id_d    = sel_idx;
        end
      end
      ST_ISSUE: begin
        if (ACK) begin
          state_d = ST_IDLE;
          irq_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  // Pending, overflow and FSM registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_q  <= '0;
      ovf_q   <= '0;
      irq_q   <= 1'b0;
      id_q    <= '0;
      state_q <= ST_IDLE;
    end else begin
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      irq_q   <= irq_d;
      id_q    <= id_d;
      state_q <= state_d;
    end
  end

  assign PEND = pend_q;
  assign OVF  = ovf_q;
  assign IRQ  = irq_q;
  assign ID   = id_q;

endmodule

// File: tb/tb_irq_pend4.sv
// Bench for irq_pend4: directed vector table, hand sequences, randomized
// run against a cycle-level reference model.
module tb_irq_pend4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0, mask = '0, mask0 = '0;
  logic       ack = 1'b0, ack0 = 1'b0;
  logic [3:0] pend, ovf, pend0, ovf0;
  logic       irq, irq0;
  logic [1:0] id, id0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  irq_pend4 #(.EDGE(1)) dut (
    .CLK(clk), .RST_N(rst_n), .REQ(req), .MASK(mask), .ACK(ack),
    .PEND(pend), .IRQ(irq), .ID(id), .OVF(ovf)
  );

  // Level-capture instance; mask0 stays 0 so it only accumulates pending bits.
  irq_pend4 #(.EDGE(0)) dut0 (
    .CLK(clk), .RST_N(rst_n), .REQ(req), .MASK(mask0), .ACK(ack0),
    .PEND(pend0), .IRQ(irq0), .ID(id0), .OVF(ovf0)
  );

  // Reference model state (EDGE=1): samples of REQ, newest first.
  logic [3:0] m_pend, m_ovf;
  logic       m_irq;
  logic [1:0] m_id;
  logic [3:0] hist[$];

  task automatic model_reset();
    m_pend = '0; m_ovf = '0; m_irq = 1'b0; m_id = '0;
    hist.delete();
  endtask

  // One clock of the model. An edge at clock t uses samples t-2 (high) and t-3 (low).
  task automatic model_tick();
    logic [3:0] ev, clr;
    ev = '0;
    if (hist.size() >= 3) ev = hist[1] & ~hist[2];
    clr = '0;
    if (m_irq && ack) clr = 4'(1 << m_id);
    if (!m_irq) begin
      if ((m_pend & mask) != 0) begin
        m_irq = 1'b1;
        for (int i = 0; i < 4; i++) if (m_pend[i] && mask[i]) m_id = 2'(i);
      end
    end else if (ack) begin
      m_irq = 1'b0;
    end
    m_ovf  = (m_ovf & ~clr) | (ev & m_pend & ~clr);
    m_pend = (m_pend & ~clr) | ev;
    hist.push_front(req);
    if (hist.size() > 3) void'(hist.pop_back());
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] m, input logic a);
    req = r; mask = m; ack = a;
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] mask;
    logic       ack;
    logic [3:0] pend;
    logic       irq;
    logic [1:0] id;
    logic [3:0] ovf;
  } vec_t;

  vec_t tbl[16];
  int   hold;
  bit   seen;

  initial begin
    tbl[0]  = '{4'b0100, 4'hF, 1'b0, 4'b0000, 1'b0, 2'd0, 4'h0};
    tbl[1]  = '{4'b0100, 4'hF, 1'b0, 4'b0000, 1'b0, 2'd0, 4'h0};
    tbl[2]  = '{4'b0100, 4'hF, 1'b0, 4'b0100, 1'b0, 2'd0, 4'h0};
    tbl[3]  = '{4'b0100, 4'hF, 1'b0, 4'b0100, 1'b1, 2'd2, 4'h0};
    tbl[4]  = '{4'b0100, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd2, 4'h0};
    tbl[5]  = '{4'b0100, 4'hF, 1'b0, 4'b0000, 1'b0, 2'd2, 4'h0};
    tbl[6]  = '{4'b0100, 4'hF, 1'b0, 4'b0000, 1'b0, 2'd2, 4'h0};
    tbl[7]  = '{4'b0011, 4'hF, 1'b0, 4'b0000, 1'b0, 2'd2, 4'h0};
    tbl[8]  = '{4'b0011, 4'hF, 1'b0, 4'b0000, 1'b0, 2'd2, 4'h0};
    tbl[9]  = '{4'b0011, 4'hF, 1'b0, 4'b0011, 1'b0, 2'd2, 4'h0};
    tbl[10] = '{4'b0011, 4'hF, 1'b0, 4'b0011, 1'b1, 2'd1, 4'h0};
    tbl[11] = '{4'b0011, 4'hF, 1'b0, 4'b0011, 1'b1, 2'd1, 4'h0};
    tbl[12] = '{4'b0011, 4'hF, 1'b1, 4'b0001, 1'b0, 2'd1, 4'h0};
    tbl[13] = '{4'b0011, 4'hF, 1'b0, 4'b0001, 1'b1, 2'd0, 4'h0};
    tbl[14] = '{4'b0011, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 4'h0};
    tbl[15] = '{4'b0011, 4'hF, 1'b0, 4'b0000, 1'b0, 2'd0, 4'h0};

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pend", pend, 4'h0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_id", id, 2'd0);
    chk("rst_ovf", ovf, 4'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) step(4'h0, 4'hF, 1'b0);

    // Single request, then two simultaneous requests
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].req, tbl[i].mask, tbl[i].ack);
      chk($sformatf("tbl%0d_pend", i), pend, tbl[i].pend);
      chk($sformatf("tbl%0d_irq", i), irq, tbl[i].irq);
      chk($sformatf("tbl%0d_id", i), id, tbl[i].id);
      chk($sformatf("tbl%0d_ovf", i), ovf, tbl[i].ovf);
    end

    // No preemption: bit 3 arrives while bit 0 is issued
    repeat (3) step(4'b0000, 4'hF, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step(4'b0001, 4'hF, 1'b0);
      seen = irq;
    end
    chk("np_irq_wait", seen, 1'b1);
    chk("np_id0", id, 2'd0);
    repeat (5) step(4'b1001, 4'hF, 1'b0);
    chk("np_hold_irq", irq, 1'b1);
    chk("np_hold_id", id, 2'd0);
    chk("np_pend", pend, 4'b1001);
    step(4'b1001, 4'hF, 1'b1);
    chk("np_ack_irq", irq, 1'b0);
    chk("np_ack_pend", pend, 4'b1000);
    step(4'b1001, 4'hF, 1'b0);
    chk("np_next_irq", irq, 1'b1);
    chk("np_next_id", id, 2'd3);
    step(4'b1001, 4'hF, 1'b1);
    chk("np_done_pend", pend, 4'b0000);
    repeat (3) step(4'b0000, 4'hF, 1'b0);

    // Masked bit accumulates, issues once unmasked
    repeat (2) step(4'b1000, 4'b0111, 1'b0);
    repeat (3) step(4'b0000, 4'b0111, 1'b0);
    chk("mask_pend", pend, 4'b1000);
    chk("mask_irq", irq, 1'b0);
    step(4'b0000, 4'hF, 1'b0);
    chk("unmask_irq", irq, 1'b1);
    chk("unmask_id", id, 2'd3);
    step(4'b0000, 4'hF, 1'b1);
    chk("unmask_ack_pend", pend, 4'b0000);
    repeat (2) step(4'b0000, 4'hF, 1'b0);

    // Overflow on bit 1, then edge coinciding with its ACK
    repeat (2) step(4'b0010, 4'b0101, 1'b0);
    repeat (3) step(4'b0000, 4'b0101, 1'b0);
    chk("ovf_first_pend", pend, 4'b0010);
    chk("ovf_first_ovf", ovf, 4'b0000);
    repeat (2) step(4'b0010, 4'b0101, 1'b0);
    repeat (3) step(4'b0000, 4'b0101, 1'b0);
    chk("ovf_set", ovf, 4'b0010);
    chk("ovf_pend", pend, 4'b0010);
    chk("ovf_irq", irq, 1'b0);
    step(4'b0000, 4'hF, 1'b0);
    chk("ovf_issue_irq", irq, 1'b1);
    chk("ovf_issue_id", id, 2'd1);
    step(4'b0010, 4'hF, 1'b0);
    step(4'b0010, 4'hF, 1'b0);
    step(4'b0000, 4'hF, 1'b1);
    chk("coinc_pend", pend, 4'b0010);
    chk("coinc_ovf", ovf, 4'b0000);
    chk("coinc_irq", irq, 1'b0);
    step(4'b0000, 4'hF, 1'b0);
    chk("coinc_reissue", irq, 1'b1);
    chk("coinc_reissue_id", id, 2'd1);
    step(4'b0000, 4'hF, 1'b1);
    chk("coinc_final_pend", pend, 4'b0000);
    repeat (2) step(4'b0000, 4'hF, 1'b0);

    // Level instance never flags overflow even though it re-captures a pending bit
    chk("lvl_ovf", ovf0, 4'h0);

    // Asynchronous reset mid-issue, REQ held high across it
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step(4'b0100, 4'hF, 1'b0);
      seen = irq;
    end
    chk("ar_irq_wait", seen, 1'b1);
    chk("ar_id", id, 2'd2);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("ar_irq", irq, 1'b0);
    chk("ar_id0", id, 2'd0);
    chk("ar_pend", pend, 4'h0);
    chk("ar_ovf", ovf, 4'h0);
    chk("ar_pend_lvl", pend0, 4'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (8) step(4'b0100, 4'hF, 1'b0);
    chk("ar_edge_ignored", pend, 4'h0);
    chk("ar_edge_noirq", irq, 1'b0);
    chk("ar_level_recap", pend0, 4'b0100);
    chk("ar_level_ovf", ovf0, 4'h0);

    // Randomized run against the model
    @(negedge clk) rst_n = 1'b0;
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    repeat (4) step(4'h0, 4'hF, 1'b0);
    hold = 0;
    for (int c = 0; c < 1500; c++) begin
      logic [3:0] r, m;
      r = req;
      m = mask;
      if (hold == 0) begin
        r = 4'($urandom);
        hold = $urandom_range(1, 4);
      end
      hold--;
      if ($urandom_range(0, 15) == 0) m = 4'($urandom);
      step(r, m, ($urandom_range(0, 2) == 0));
      chk("rnd_pend", pend, m_pend);
      chk("rnd_irq", irq, m_irq);
      if (m_irq) chk("rnd_id", id, m_id);
      chk("rnd_ovf", ovf, m_ovf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
